// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// One command is accepted per IDLE cycle and walks IDLE -> ACCESS (-> RESP
// for reads) -> IDLE. The memory registers read data on the ACCESS edge, so
// RESP passes mem_data_out straight through to the winner's rdata.
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie
// breaking. When it is undefined, port 0 wins every tie.
module dmem_arbiter #(
  parameter int addresswidth = 32,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [addresswidth-1:0] p0_addr,
  input  logic [width-1:0]        p0_wdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [addresswidth-1:0] p1_addr,
  input  logic [width-1:0]        p1_wdata,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [width-1:0]        p0_rdata,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [width-1:0]        p1_rdata,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [width-1:0]        mem_data_in,
  input  logic [width-1:0]        mem_data_out,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [addresswidth-1:0] addr_q, addr_d;
  logic [width-1:0]        wdata_q, wdata_d;
  logic                    port_q, port_d;   // 0 = port 0 owns the transaction
  logic                    win;              // port selected in IDLE

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;                        // port preferred on the next tie

  // Tie goes to the pointer; a lone request wins outright.
  always_comb begin
    win = (p0_req && p1_req) ? ptr_q : !p0_req;
  end
`else
  // Fixed priority: port 0 whenever it is requesting.
  always_comb begin
    win = !p0_req;
  end
`endif

  // State and command registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next state; the command is captured only when leaving IDLE, so input
  // changes during ACCESS/RESP have no effect.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d = ACCESS;
          port_d  = win;
          we_d    = win ? p1_we    : p0_we;
          addr_d  = win ? p1_addr  : p0_addr;
          wdata_d = win ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          ptr_d   = !win;
`endif
        end
      end
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign busy         = (state_q != IDLE);
  assign mem_address  = addr_q;
  assign mem_data_in  = wdata_q;
  assign mem_write_en = (state_q == ACCESS) &&  we_q;
  assign mem_read_en  = (state_q == ACCESS) && !we_q;

  assign p0_gnt    = (state_q == ACCESS) && !port_q;
  assign p1_gnt    = (state_q == ACCESS) &&  port_q;
  assign p0_rvalid = (state_q == RESP)   && !port_q;
  assign p1_rvalid = (state_q == RESP)   &&  port_q;
  assign p0_rdata  = p0_rvalid ? mem_data_out : '0;
  assign p1_rdata  = p1_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory environment, a transaction-level
// reference model (grant time, free time, expected data), a per-cycle compare
// process and directed scenarios with literal expectations.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_write_en, mem_read_en, busy;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.addresswidth(AW), .width(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment memory: writes land on the edge, reads are registered.
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_write_en) env_mem[mem_address] = mem_data_in;
    if (mem_read_en)  mem_data_out <= env_mem.exists(mem_address) ? env_mem[mem_address] : '0;
  end

  // Reference model: t is the index of the cycle that follows each edge.
  // A winner picked at edge t owns cycle t (ACCESS) and, for reads, t+1
  // (RESP). m_free is the first cycle the arbiter is idle again.
  int            t = 0, m_acc = -100, m_free = 0;
  bit            m_port = 1'b0, m_we = 1'b0, m_last = 1'b1, m_w = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [DW-1:0] m_mem [logic [AW-1:0]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acc = -100; m_free = 0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
    end else begin
      t++;
      if (t - 1 >= m_free && (p0_req || p1_req)) begin
        if (p0_req && p1_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          m_w = !m_last;
`else
          m_w = 1'b0;
`endif
        end else m_w = p1_req;
        m_last  = m_w;
        m_port  = m_w;
        m_we    = m_w ? p1_we    : p0_we;
        m_addr  = m_w ? p1_addr  : p0_addr;
        m_wdata = m_w ? p1_wdata : p0_wdata;
        m_acc   = t;
        m_free  = m_we ? t + 1 : t + 2;
        if (m_we) m_mem[m_addr] = m_wdata;
        else      m_rdata = m_mem.exists(m_addr) ? m_mem[m_addr] : '0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_acc, e_rv;
    e_acc = (t == m_acc);
    e_rv  = (t == m_acc + 1) && !m_we;
    chk1 ("p0_gnt",       p0_gnt,       e_acc && !m_port);
    chk1 ("p1_gnt",       p1_gnt,       e_acc &&  m_port);
    chk1 ("p0_rvalid",    p0_rvalid,    e_rv  && !m_port);
    chk1 ("p1_rvalid",    p1_rvalid,    e_rv  &&  m_port);
    chk32("p0_rdata",     p0_rdata,     (e_rv && !m_port) ? m_rdata : '0);
    chk32("p1_rdata",     p1_rdata,     (e_rv &&  m_port) ? m_rdata : '0);
    chk1 ("mem_write_en", mem_write_en, e_acc &&  m_we);
    chk1 ("mem_read_en",  mem_read_en,  e_acc && !m_we);
    chk32("mem_address",  mem_address,  m_addr);
    chk32("mem_data_in",  mem_data_in,  m_wdata);
    chk1 ("busy",         busy,         (t >= m_acc) && (t < m_free));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
    else           begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
  endtask

  // Waits (bounded) for the given port's grant; returns in the ACCESS cycle.
  task automatic wait_gnt(input int port, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if ((port == 0) ? p0_gnt : p1_gnt) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: gnt got 0 expected 1 within 20 cycles", tag);
    end
  endtask

  int ord[$];
  int exp_ord[4];
  int rv_at[$];

  initial begin
    // Reset state
    repeat (3) step();
    chk1 ("rst_busy",  busy, 1'b0);
    chk32("rst_addr",  mem_address, 32'h0);
    chk32("rst_wdata", mem_data_in, 32'h0);
    chk1 ("rst_gnt",   p0_gnt, 1'b0);
    chk32("rst_rdata", p0_rdata, 32'h0);
    reset = 1'b0;
    step();

    // Single write from port 0
    set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    wait_gnt(0, "wr_gnt");
    chk1 ("wr_we",   mem_write_en, 1'b1);
    chk1 ("wr_re",   mem_read_en, 1'b0);
    chk32("wr_addr", mem_address, 32'h10);
    chk32("wr_data", mem_data_in, 32'hDEADBEEF);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk1("wr_idle_after", busy, 1'b0);
    repeat (2) step();

    // Read-back from port 1
    set_port(1, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_gnt(1, "rd_gnt");
    chk1("rd_re", mem_read_en, 1'b1);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk1 ("rd_p1_rvalid", p1_rvalid, 1'b1);
    chk32("rd_p1_rdata",  p1_rdata, 32'hDEADBEEF);
    chk1 ("rd_p0_rvalid", p0_rvalid, 1'b0);
    repeat (2) step();

    // Tie with both requests held for four grants
    set_port(0, 1'b1, 1'b1, 32'h40, 32'h1111_0000);
    set_port(1, 1'b1, 1'b1, 32'h44, 32'h2222_0000);
    for (int i = 0; i < 40 && ord.size() < 4; i++) begin
      step();
      if (p0_gnt) ord.push_back(0);
      if (p1_gnt) ord.push_back(1);
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    chk32("tie_count", ord.size(), 4);
    for (int i = 0; i < 4; i++)
      chk32($sformatf("tie_order[%0d]", i), (i < ord.size()) ? ord[i] : -1, exp_ord[i]);
    repeat (3) step();

    // Reset in the ACCESS cycle of a read at 0x20
    set_port(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    wait_gnt(0, "pre_rst_wr_gnt");
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) step();
    set_port(0, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_gnt(0, "rst_rd_gnt");
    chk1("rst_rd_re", mem_read_en, 1'b1);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_re",   mem_read_en, 1'b0);
    chk1("abort_we",   mem_write_en, 1'b0);
    chk1("abort_gnt",  p0_gnt, 1'b0);
    step();
    chk1("abort_rvalid", p0_rvalid, 1'b0);
    reset = 1'b0;
    step();
    set_port(0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    chk1("post_rst_tie_p0", p0_gnt, 1'b1);
    chk1("post_rst_tie_p1", p1_gnt, 1'b0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_gnt(1, "post_rst_p1_gnt");
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();

    // Request raised during another port's ACCESS is not seen until IDLE
    set_port(0, 1'b1, 1'b1, 32'h50, 32'hCAFE_F00D);
    wait_gnt(0, "late_p0_gnt");
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b1, 32'h54, 32'h0BAD_F00D);
    step();
    chk1("late_idle_no_gnt", p1_gnt, 1'b0);
    chk1("late_idle_busy",   busy, 1'b0);
    step();
    chk1("late_p1_gnt", p1_gnt, 1'b1);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();

    // Back-to-back reads from port 0: one rvalid every three cycles
    set_port(0, 1'b1, 1'b0, 32'h54, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (p0_rvalid) begin
        rv_at.push_back(i);
        chk32("tp_rdata", p0_rdata, 32'h0BAD_F00D);
      end
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk32("tp_rvalid_count", rv_at.size(), 4);
    for (int i = 1; i < rv_at.size(); i++)
      chk32("tp_spacing", rv_at[i] - rv_at[i-1], 3);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard stop in case the flow above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
